// File: rtl/mod6_load_counter_if.sv
// Load/count bus for mod6_load_counter.
// TC exists only when MOD6_TC_EN is defined.
interface mod6_load_counter_if #(
  parameter int WIDTH = 3
);
  logic             LC;
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] Q;
`ifdef MOD6_TC_EN
  logic             TC;
`endif

  modport master (
    output LC,
    output I,
`ifdef MOD6_TC_EN
    input  TC,
`endif
    input  Q
  );

  modport slave (
    input  LC,
    input  I,
`ifdef MOD6_TC_EN
    output TC,
`endif
    output Q
  );
endinterface

// File: rtl/mod6_load_counter.sv
// Loadable modulo-MODULUS up-counter, async active-low clear.
// Optional terminal-count output TC under macro MOD6_TC_EN.
module mod6_load_counter #(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 3
) (
  input logic CLK,
  input logic CLR,
  mod6_load_counter_if.slave bus
);
  localparam logic [WIDTH:0]   MODW = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic             ld_ok;

  // a load value at or above MODULUS is never accepted as a state
  always_comb begin
    ld_ok = ({1'b0, bus.I} < MODW);
  end

  // next count: load has priority; bad loads and wrap go to 0
  always_comb begin
    q_nxt = '0;
    unique case (1'b1)
      bus.LC: begin
        if (ld_ok) q_nxt = bus.I;
      end
      !bus.LC: begin
        if (q != LAST) q_nxt = q + WIDTH'(1);
      end
    endcase
  end

  // count register; clear acts immediately, independent of CLK
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) q <= '0;
    else      q <= q_nxt;
  end

  assign bus.Q = q;

`ifdef MOD6_TC_EN
  assign bus.TC = CLR && !bus.LC && (q == LAST);
`endif
endmodule

// File: tb/tb_mod6_load_counter.sv
// Directed bench for mod6_load_counter with a reference model.
// Builds with or without MOD6_TC_EN.
module tb_mod6_load_counter;
  localparam int MOD = 6;
  localparam int W   = 3;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  int   vec = 0;
  int   err = 0;
  int   m   = 0;

  mod6_load_counter_if #(.WIDTH(W)) bus ();

  mod6_load_counter #(.MODULUS(MOD), .WIDTH(W)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // reference: count value from the rules, as plain integers
  always @(posedge CLK or negedge CLR) begin
    if (!CLR)        m = 0;
    else if (bus.LC) m = (int'(bus.I) < MOD) ? int'(bus.I) : 0;
    else             m = (m + 1) % MOD;
  end

  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // every falling edge: DUT against the model
  always @(negedge CLK) begin
    chk("model_q", int'(bus.Q), m);
`ifdef MOD6_TC_EN
    chk("model_tc", int'(bus.TC), int'(m == MOD - 1 && !bus.LC && CLR));
`endif
  end

  task automatic cyc(input logic lc, input logic [W-1:0] i);
    @(negedge CLK);
    #1;
    bus.LC = lc;
    bus.I  = i;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    int cnt_exp [6];
    int sw_exp [8];
    cnt_exp = '{3, 4, 5, 0, 1, 2};
    sw_exp  = '{0, 1, 2, 3, 4, 5, 0, 0};
    bus.LC = 1'b0;
    bus.I  = '0;

    // clear before any clock edge
    #1 CLR = 1'b0;
    #1 chk("clr_async", int'(bus.Q), 0);
    repeat (2) cyc(1'b0, 3'd0);
    chk("clr_hold", int'(bus.Q), 0);
    @(negedge CLK);
    #1 CLR = 1'b1;
    @(posedge CLK);
    #1 chk("release", int'(bus.Q), 1);

    // load then hold
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 3'd1);
      chk("load_hold", int'(bus.Q), 1);
    end
    #2 CLR = 1'b0;
    #1 chk("clr_pulse", int'(bus.Q), 0);
    #1 CLR = 1'b1;

    // load then count
    cyc(1'b1, 3'd2);
    chk("load2", int'(bus.Q), 2);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 3'd7);
      chk("count", int'(bus.Q), cnt_exp[k]);
    end

    // wrap from 0
    cyc(1'b1, 3'd0);
    chk("load0", int'(bus.Q), 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 3'd0);
      chk("wrap", int'(bus.Q), k % 6);
`ifdef MOD6_TC_EN
      chk("wrap_tc", int'(bus.TC), int'(k == 5));
`endif
    end

    // illegal loads
    cyc(1'b1, 3'd3);
    chk("load3", int'(bus.Q), 3);
    cyc(1'b1, 3'd6);
    chk("ill6", int'(bus.Q), 0);
    cyc(1'b1, 3'd4);
    chk("load4", int'(bus.Q), 4);
    cyc(1'b1, 3'd7);
    chk("ill7", int'(bus.Q), 0);
    cyc(1'b1, 3'd5);
    chk("load5", int'(bus.Q), 5);
`ifdef MOD6_TC_EN
    chk("tc_lc1", int'(bus.TC), 0);
`endif
    cyc(1'b0, 3'd5);
    chk("5_wrap", int'(bus.Q), 0);

    // load sweep of every input code
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 3'(k));
      chk("sweep", int'(bus.Q), sw_exp[k]);
    end

    // clear beats load across several edges
    cyc(1'b1, 3'd3);
    chk("pre_clr", int'(bus.Q), 3);
    @(negedge CLK);
    #1 CLR = 1'b0;
    #1 chk("clr_prio", int'(bus.Q), 0);
    repeat (3) begin
      @(posedge CLK);
      #1 chk("clr_prio_edge", int'(bus.Q), 0);
    end
    @(negedge CLK);
    #1 CLR = 1'b1;
    @(posedge CLK);
    #1 chk("post_clr", int'(bus.Q), 3);
    repeat (2) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
